// File: rtl/dnn_pkg.sv
// ============================================================================
// Module      : dnn_pkg
// Description : Shared widths, counter constants and FSM state encoding for
//               the DNN output-layer stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dnn_pkg;

    localparam int ACT_W  = 21;
    localparam int WGT_W  = 5;
    localparam int PROD_W = 26;
    localparam int ACC_W  = 28;
    localparam int N_HID  = 4;
    localparam int N_OUT  = 2;

    // One MAC step per (hidden node, output node) pair
    localparam int               CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_HID * N_OUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : dnn_pkg

`default_nettype wire

// File: rtl/dnn_mac.sv
// ============================================================================
// Module      : dnn_mac
// Description : Shared signed 21x5 multiplier with the two output-node
//               accumulators; operand and accumulator chosen by step count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dnn_mac
    import dnn_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_clr,
    input  logic                          i_step,
    input  logic [CNT_W-1:0]              i_cnt,
    input  logic [N_HID*ACT_W-1:0]        i_h,
    input  logic [N_HID*N_OUT*WGT_W-1:0]  i_w,
    output logic signed [ACC_W-1:0]       o_acc8,
    output logic signed [ACC_W-1:0]       o_acc9
);

    logic        [1:0]        w_hidx;
    logic signed [ACT_W-1:0]  w_h;
    logic signed [WGT_W-1:0]  w_w;
    logic signed [PROD_W-1:0] w_h_ext;
    logic signed [PROD_W-1:0] w_w_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;

    logic signed [ACC_W-1:0]  r_acc8;
    logic signed [ACC_W-1:0]  r_acc9;

    // Weights are packed in step order: w48,w58,w68,w78,w49,w59,w69,w79
    assign w_hidx     = i_cnt[1:0];
    assign w_h        = i_h[int'(w_hidx) * ACT_W +: ACT_W];
    assign w_w        = i_w[int'(i_cnt) * WGT_W +: WGT_W];
    assign w_h_ext    = PROD_W'(w_h);
    assign w_w_ext    = PROD_W'(w_w);
    assign w_prod     = w_h_ext * w_w_ext;
    assign w_prod_ext = ACC_W'(w_prod);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc8 <= '0;
            r_acc9 <= '0;
        end else if (i_step) begin
            if (i_cnt[2]) begin
                r_acc9 <= r_acc9 + w_prod_ext;
            end else begin
                r_acc8 <= r_acc8 + w_prod_ext;
            end
        end
    end

    assign o_acc8 = r_acc8;
    assign o_acc9 = r_acc9;

endmodule : dnn_mac

`default_nettype wire

// File: rtl/dnn_stage2.sv
// ============================================================================
// Module      : dnn_stage2
// Description : Output layer (2 nodes, 4 inputs) computed serially on one
//               multiplier, followed by argmax; fixed 9-edge latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dnn_stage2
    import dnn_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [ACT_W-1:0]   h0,
    input  logic signed [ACT_W-1:0]   h1,
    input  logic signed [ACT_W-1:0]   h2,
    input  logic signed [ACT_W-1:0]   h3,
    input  logic signed [WGT_W-1:0]   w48,
    input  logic signed [WGT_W-1:0]   w58,
    input  logic signed [WGT_W-1:0]   w68,
    input  logic signed [WGT_W-1:0]   w78,
    input  logic signed [WGT_W-1:0]   w49,
    input  logic signed [WGT_W-1:0]   w59,
    input  logic signed [WGT_W-1:0]   w69,
    input  logic signed [WGT_W-1:0]   w79,
    input  logic                      stg_2_rdy,
    output logic                      in_ready,
    output logic signed [ACC_W-1:0]   z8,
    output logic signed [ACC_W-1:0]   z9,
    output logic                      cls,
    output logic                      stg_3_rdy
);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic                            w_clr;
    logic                            w_step;
    logic [CNT_W-1:0]                r_cnt;
    logic [N_HID*ACT_W-1:0]          r_h;
    logic [N_HID*N_OUT*WGT_W-1:0]    r_w;
    logic signed [ACC_W-1:0]         w_acc8;
    logic signed [ACC_W-1:0]         w_acc9;
    logic signed [ACC_W-1:0]         r_z8;
    logic signed [ACC_W-1:0]         r_z9;
    logic                            r_cls;
    logic                            r_stg_3_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (stg_2_rdy) begin
                    w_clr       = 1'b1;
                    w_state_nxt = MAC;
                end
            end
            MAC: begin
                w_step = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operands are frozen at accept so upstream may change freely during MAC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_h   <= '0;
            r_w   <= '0;
        end else if (w_clr) begin
            r_cnt <= '0;
            r_h   <= {h3, h2, h1, h0};
            r_w   <= {w79, w69, w59, w49, w78, w68, w58, w48};
        end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    dnn_mac u_mac (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_step (w_step),
        .i_cnt  (r_cnt),
        .i_h    (r_h),
        .i_w    (r_w),
        .o_acc8 (w_acc8),
        .o_acc9 (w_acc9)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_z8        <= '0;
            r_z9        <= '0;
            r_cls       <= 1'b0;
            r_stg_3_rdy <= 1'b0;
        end else if (r_state == DONE) begin
            r_z8        <= w_acc8;
            r_z9        <= w_acc9;
            r_cls       <= (w_acc9 > w_acc8);
            r_stg_3_rdy <= 1'b1;
        end else begin
            r_stg_3_rdy <= 1'b0;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign z8        = r_z8;
    assign z9        = r_z9;
    assign cls       = r_cls;
    assign stg_3_rdy = r_stg_3_rdy;

endmodule : dnn_stage2

`default_nettype wire

// File: tb/tb_dnn_stage2.sv
// ============================================================================
// Module      : tb_dnn_stage2
// Description : Directed vector bench for dnn_stage2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dnn_stage2;

    logic               clk;
    logic               rst;
    logic signed [20:0] h0, h1, h2, h3;
    logic signed [4:0]  w48, w58, w68, w78, w49, w59, w69, w79;
    logic               stg_2_rdy;
    logic               in_ready;
    logic signed [27:0] z8, z9;
    logic               cls;
    logic               stg_3_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0][20:0] h;
        logic [3:0][4:0]  w8;
        logic [3:0][4:0]  w9;
        logic signed [27:0] z8;
        logic signed [27:0] z9;
        logic               cls;
    } vec_t;

    localparam int NV = 5;
    vec_t tv [NV];

    dnn_stage2 dut (
        .clk       (clk),
        .rst       (rst),
        .h0        (h0),
        .h1        (h1),
        .h2        (h2),
        .h3        (h3),
        .w48       (w48),
        .w58       (w58),
        .w68       (w68),
        .w78       (w78),
        .w49       (w49),
        .w59       (w59),
        .w69       (w69),
        .w79       (w79),
        .stg_2_rdy (stg_2_rdy),
        .in_ready  (in_ready),
        .z8        (z8),
        .z9        (z9),
        .cls       (cls),
        .stg_3_rdy (stg_3_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int a0, a1, a2, a3,
                                input int p0, p1, p2, p3,
                                input int q0, q1, q2, q3,
                                input int ez8, ez9, input int ecls);
        vec_t v;
        v.h[0] = 21'(a0); v.h[1] = 21'(a1); v.h[2] = 21'(a2); v.h[3] = 21'(a3);
        v.w8[0] = 5'(p0); v.w8[1] = 5'(p1); v.w8[2] = 5'(p2); v.w8[3] = 5'(p3);
        v.w9[0] = 5'(q0); v.w9[1] = 5'(q1); v.w9[2] = 5'(q2); v.w9[3] = 5'(q3);
        v.z8  = 28'(ez8);
        v.z9  = 28'(ez9);
        v.cls = ecls[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        h0 = v.h[0];  h1 = v.h[1];  h2 = v.h[2];  h3 = v.h[3];
        w48 = v.w8[0]; w58 = v.w8[1]; w68 = v.w8[2]; w78 = v.w8[3];
        w49 = v.w9[0]; w59 = v.w9[1]; w69 = v.w9[2]; w79 = v.w9[3];
    endtask

    task automatic scramble();
        h0 = 21'($urandom); h1 = 21'($urandom); h2 = 21'($urandom); h3 = 21'($urandom);
        w48 = 5'($urandom); w58 = 5'($urandom); w68 = 5'($urandom); w78 = 5'($urandom);
        w49 = 5'($urandom); w59 = 5'($urandom); w69 = 5'($urandom); w79 = 5'($urandom);
    endtask

    // Accept one vector, then scramble inputs and measure latency to the pulse
    task automatic run_txn(input vec_t v, input string tag);
        int n;
        int lat;
        @(negedge clk);
        apply(v);
        stg_2_rdy = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " in_ready before accept"}, in_ready, 1);
        @(posedge clk);
        #1;
        stg_2_rdy = 1'b0;
        scramble();
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (stg_3_rdy) begin
                lat = i;
                break;
            end
        end
        chk({tag, " latency"}, lat, 9);
        chk({tag, " z8"}, z8, v.z8);
        chk({tag, " z9"}, z9, v.z9);
        chk({tag, " cls"}, cls, v.cls);
        @(posedge clk);
        #1;
        chk({tag, " pulse width"}, stg_3_rdy, 0);
        chk({tag, " z8 hold"}, z8, v.z8);
        chk({tag, " in_ready after"}, in_ready, 1);
    endtask

    initial begin
        tv[0] = mk(1, 2, 3, 4,  1, 1, 1, 1,  -1, 0, 0, 2,  10, 7, 0);
        tv[1] = mk(1048575, 1048575, 1048575, 1048575,  -16, -16, -16, -16,
                   15, 15, 15, 15,  -67108800, 62914500, 1);
        tv[2] = mk(5, 0, 0, 0,  3, 0, 0, 0,  3, 0, 0, 0,  15, 15, 0);
        tv[3] = mk(-1048576, 7, -3, 0,  2, -3, 5, -16,  -16, 1, 0, 4,
                   -2097188, 16777223, 1);
        tv[4] = mk(100, -200, 300, -400,  -1, -1, -1, -1,  1, 2, 3, 4,
                   200, -1000, 0);

        rst = 1'b1;
        stg_2_rdy = 1'b0;
        apply(tv[0]);
        repeat (3) @(posedge clk);
        #1;
        chk("reset z8", z8, 0);
        chk("reset z9", z9, 0);
        chk("reset cls", cls, 0);
        chk("reset stg_3_rdy", stg_3_rdy, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready after reset", in_ready, 1);

        for (int k = 0; k < NV; k++) begin
            run_txn(tv[k], $sformatf("vec%0d", k));
        end

        // Back-to-back with stg_2_rdy held high and inputs churning
        @(negedge clk);
        stg_2_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 0) apply(tv[0]);
            else if (k == 10) apply(tv[4]);
            else scramble();
            @(posedge clk);
            #1;
            chk($sformatf("b2b in_ready e%0d", k), in_ready, (k == 9 || k == 19) ? 1 : 0);
            chk($sformatf("b2b stg_3_rdy e%0d", k), stg_3_rdy, (k == 9 || k == 19) ? 1 : 0);
            if (k == 9) begin
                chk("b2b A z8", z8, tv[0].z8);
                chk("b2b A z9", z9, tv[0].z9);
            end
            if (k == 19) begin
                chk("b2b B z8", z8, tv[4].z8);
                chk("b2b B z9", z9, tv[4].z9);
                chk("b2b B cls", cls, tv[4].cls);
            end
            @(negedge clk);
            if (k == 19) stg_2_rdy = 1'b0;
        end

        // Reset in the middle of MAC (cnt=4 step) discards the transaction
        @(negedge clk);
        apply(tv[1]);
        stg_2_rdy = 1'b1;
        @(posedge clk);
        #1;
        stg_2_rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst z8", z8, 0);
        chk("midrst z9", z9, 0);
        chk("midrst cls", cls, 0);
        chk("midrst stg_3_rdy", stg_3_rdy, 0);
        chk("midrst in_ready", in_ready, 1);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                #1;
                if (stg_3_rdy) seen++;
            end
            chk("midrst no pulse", seen, 0);
        end
        run_txn(tv[0], "post-rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dnn_stage2

`default_nettype wire
